// File: rtl/hub75_bcm_scanner.sv
// HUB75 row scanner: streams packed dual-half pixels from frame RAM into the column drivers
// while the previous row stays lit, weighting rows by thermometer PWM or binary-coded modulation.
module hub75_bcm_scanner #(
  parameter int unsigned COLS      = 160,
  parameter int unsigned ROW_PAIRS = 20,
  parameter int unsigned ROW_W     = 5,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned RAM_LAT   = 1,
  parameter int unsigned UNIT      = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  input  logic [7:0]         i_brightness,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_rd_addr,
  input  logic [6*DEPTH-1:0] i_rd_data,
  output logic               o_data_clock,
  output logic               o_data_latch,
  output logic               o_data_blank,
  output logic [1:0]         o_data_r,
  output logic [1:0]         o_data_g,
  output logic [1:0]         o_data_b,
  output logic [ROW_W-1:0]   o_row_select,
  output logic               o_frame_done
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PH_W  = $clog2(RAM_LAT + 2);
  localparam int unsigned SUB_W = DEPTH;
  localparam int unsigned WMAX  = UNIT << (DEPTH - 1);
  localparam int unsigned WIN_W = $clog2(WMAX + 1);
  localparam int unsigned CMP_W = WIN_W + 9;

  typedef enum logic [2:0] {
    StReset, StShift, StWait, StBlank, StLatch, StAdvance, StUnblank
  } state_e;

  state_e             r_state, w_state_next;
  logic [COL_W-1:0]   r_col;
  logic [PH_W-1:0]    r_ph;
  logic [ROW_W-1:0]   r_row;
  logic [ROW_W-1:0]   r_disp_row;
  logic [SUB_W-1:0]   r_sub;
  logic               r_mode;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   r_wlen;
  logic [1:0]         r_r, r_g, r_b;

  logic [5:0]         w_bits;
  logic               w_data_ph, w_clk_ph, w_last_col, w_last_row, w_last_sub, w_lit;
  logic [SUB_W-1:0]   w_first_sub;
  logic [WIN_W-1:0]   w_win_len, w_elapsed;

  function automatic logic sel_bit(input logic [DEPTH-1:0] val, input logic bcm,
                                   input logic [SUB_W-1:0] sub);
    logic [DEPTH-1:0] shifted;
    shifted = val >> sub;
    return bcm ? shifted[0] : (val >= sub);
  endfunction

  // w_bits[5:0] = {R0, G0, B0, R1, G1, B1}
  for (genvar gi = 0; gi < 6; gi++) begin : g_sel
    assign w_bits[gi] = sel_bit(i_rd_data[gi*DEPTH +: DEPTH], r_mode, r_sub);
  end

  assign w_data_ph   = (r_state == StShift) && (r_ph == PH_W'(RAM_LAT));
  assign w_clk_ph    = (r_state == StShift) && (r_ph == PH_W'(RAM_LAT + 1));
  assign w_last_col  = (r_col == COL_W'(COLS - 1));
  assign w_last_row  = (r_row == ROW_W'(ROW_PAIRS - 1));
  assign w_last_sub  = r_mode ? (r_sub == SUB_W'(DEPTH - 1)) : (r_sub == SUB_W'((1 << DEPTH) - 1));
  assign w_first_sub = i_mode ? '0 : SUB_W'(1);
  assign w_win_len   = r_mode ? WIN_W'(UNIT << r_sub) : WIN_W'(UNIT);
  assign w_elapsed   = r_wlen - r_win;
  // Lit while elapsed/W < (brightness+1)/256, evaluated without division.
  assign w_lit = CMP_W'({w_elapsed, 8'h00}) <
                 (CMP_W'(r_wlen) * (CMP_W'(i_brightness) + CMP_W'(1)));

  assign o_rd_en      = (r_state == StShift) && (r_ph == '0);
  assign o_rd_addr    = ADDR_W'(32'(r_row) * COLS + 32'(r_col));
  assign o_data_clock = w_clk_ph;
  assign o_data_latch = (r_state == StLatch);
  assign o_data_blank = o_data_latch || (r_win == '0) || !w_lit;
  assign o_data_r     = w_data_ph ? {w_bits[2], w_bits[5]} : r_r;
  assign o_data_g     = w_data_ph ? {w_bits[1], w_bits[4]} : r_g;
  assign o_data_b     = w_data_ph ? {w_bits[0], w_bits[3]} : r_b;
  assign o_row_select = r_disp_row;
  assign o_frame_done = o_data_latch && w_last_row && w_last_sub;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StReset:   w_state_next = StShift;
      StShift:   if (w_clk_ph && w_last_col) w_state_next = StWait;
      StWait:    if (r_win == '0) w_state_next = StBlank;
      StBlank:   w_state_next = StLatch;
      StLatch:   w_state_next = StAdvance;
      StAdvance: w_state_next = StUnblank;
      StUnblank: w_state_next = StShift;
      default:   w_state_next = StReset;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StReset;
      r_col      <= '0;
      r_ph       <= '0;
      r_row      <= '0;
      r_disp_row <= '0;
      r_sub      <= '0;
      r_mode     <= 1'b0;
      r_win      <= '0;
      r_wlen     <= '0;
      r_r        <= '0;
      r_g        <= '0;
      r_b        <= '0;
    end else begin
      r_state <= w_state_next;
      // The displayed row's window runs down while the next row shifts in.
      if (r_win != '0) r_win <= r_win - WIN_W'(1);
      case (r_state)
        StReset: begin
          r_mode <= i_mode;
          r_sub  <= w_first_sub;
        end
        StShift: begin
          if (w_data_ph) begin
            r_r <= {w_bits[2], w_bits[5]};
            r_g <= {w_bits[1], w_bits[4]};
            r_b <= {w_bits[0], w_bits[3]};
          end
          if (w_clk_ph) begin
            r_ph  <= '0;
            r_col <= w_last_col ? '0 : r_col + COL_W'(1);
          end else begin
            r_ph <= r_ph + PH_W'(1);
          end
        end
        StAdvance: r_disp_row <= r_row;
        StUnblank: begin
          r_win  <= w_win_len;
          r_wlen <= w_win_len;
          if (w_last_row) begin
            r_row <= '0;
            if (w_last_sub) begin
              r_mode <= i_mode;
              r_sub  <= w_first_sub;
            end else begin
              r_sub <= r_sub + SUB_W'(1);
            end
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner: small panel (4 cols, 2 row pairs, 2-bit colour),
// one instance with RAM_LAT=1 and one with RAM_LAT=3.
module tb_hub75_bcm_scanner;
  localparam int COLS = 4, ROWS = 2, DEPTH = 2, AW = 8, RW = 2, UNIT = 8;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rst_b = 1'b1, mode = 1'b0, mode_b = 1'b0;
  logic [7:0] bright = 8'd255, bright_b = 8'd255;

  logic rd_en, dclk, latch, blank, done;
  logic [AW-1:0] rd_addr;
  logic [11:0] rd_data = '0;
  logic [1:0] r, g, b;
  logic [RW-1:0] row_sel;

  logic rd_en_b, dclk_b, latch_b, blank_b, done_b;
  logic [AW-1:0] rd_addr_b;
  logic [11:0] rd_data_b = '0, p1_b = '0, p2_b = '0;
  logic [1:0] r_b, g_b, b_b;
  logic [RW-1:0] row_sel_b;

  hub75_bcm_scanner #(.COLS(COLS), .ROW_PAIRS(ROWS), .ROW_W(RW), .DEPTH(DEPTH), .ADDR_W(AW),
                      .RAM_LAT(1), .UNIT(UNIT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_brightness(bright),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_data_clock(dclk), .o_data_latch(latch), .o_data_blank(blank),
    .o_data_r(r), .o_data_g(g), .o_data_b(b), .o_row_select(row_sel), .o_frame_done(done)
  );

  hub75_bcm_scanner #(.COLS(COLS), .ROW_PAIRS(ROWS), .ROW_W(RW), .DEPTH(DEPTH), .ADDR_W(AW),
                      .RAM_LAT(3), .UNIT(UNIT)) u_dut3 (
    .i_clk(clk), .i_rst(rst_b), .i_mode(mode_b), .i_brightness(bright_b),
    .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b), .i_rd_data(rd_data_b),
    .o_data_clock(dclk_b), .o_data_latch(latch_b), .o_data_blank(blank_b),
    .o_data_r(r_b), .o_data_g(g_b), .o_data_b(b_b), .o_row_select(row_sel_b),
    .o_frame_done(done_b)
  );

  // Frame RAM word {R0,G0,B0,R1,G1,B1}: R0=2'b10 and G1=2 everywhere, the rest vary by address.
  function automatic logic [11:0] mem_word(input int a);
    logic [2:0] x;
    x = a[2:0];
    return {2'b10, x[1:0], ~x[1:0], {1'b0, x[2]}, 2'b10, x[1:0] ^ 2'b01};
  endfunction

  // Expected pins {r[1],r[0],g[1],g[0],b[1],b[0]}; bit 1 = lower half (R1/G1/B1).
  function automatic logic [5:0] exp_pix(input int a, input logic bcm, input int sub);
    logic [11:0] w;
    logic [1:0] v;
    logic [5:0] s;
    w = mem_word(a);
    for (int i = 0; i < 6; i++) begin
      v = w[i*2 +: 2];
      s[i] = bcm ? v[sub[0]] : (int'(v) >= sub);
    end
    return {s[2], s[5], s[1], s[4], s[0], s[3]};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_word(int'(rd_addr));
  always @(posedge clk) begin
    p1_b      <= mem_word(int'(rd_addr_b));
    p2_b      <= p1_b;
    rd_data_b <= p2_b;
  end

  int n_cmp = 0, n_err = 0;
  int cap_addr[0:7];
  logic [5:0] cap_pix[0:7];
  int cap_n_addr, cap_n_pix, cap_blank_low, cap_done;
  logic cap_timeout;
  logic [RW-1:0] cap_rowsel;

  // Records one row's shift up to and including its latch, then row_select once updated.
  task automatic capture_row();
    bit got;
    got = 0; cap_n_addr = 0; cap_n_pix = 0; cap_blank_low = 0; cap_done = 0;
    cap_timeout = 1'b0; cap_rowsel = '1;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      @(negedge clk);
      if (rd_en) begin
        if (cap_n_addr < 8) cap_addr[cap_n_addr] = int'(rd_addr);
        cap_n_addr++;
      end
      if (dclk) begin
        if (cap_n_pix < 8) cap_pix[cap_n_pix] = {r, g, b};
        cap_n_pix++;
      end
      if (!blank) cap_blank_low++;
      if (done) cap_done++;
      if (latch) got = 1;
    end
    if (!got) cap_timeout = 1'b1;
    else begin
      repeat (2) @(negedge clk);
      cap_rowsel = row_sel;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({rd_en, dclk, latch, done} !== 4'b0) begin n_err++;
      $display("FAIL reset_strobes: got %b want 0000", {rd_en, dclk, latch, done}); end
    n_cmp++; if (blank !== 1'b1) begin n_err++; $display("FAIL reset_blank: got %b want 1", blank); end
    n_cmp++; if (rd_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
    n_cmp++; if ({r, g, b} !== 6'b0) begin n_err++; $display("FAIL reset_rgb: got %b want 0", {r, g, b}); end
    n_cmp++; if (row_sel !== '0) begin n_err++; $display("FAIL reset_row: got %0d want 0", row_sel); end
  endtask

  task automatic test_first_rows();
    rst = 1'b0;
    for (int row = 0; row < ROWS; row++) begin
      capture_row();
      n_cmp++; if (cap_timeout !== 1'b0) begin n_err++; $display("FAIL first_timeout row%0d: got latch none want latch", row); end
      n_cmp++; if (cap_n_addr != COLS) begin n_err++; $display("FAIL first_nreads row%0d: got %0d want %0d", row, cap_n_addr, COLS); end
      n_cmp++; if (cap_n_pix != COLS) begin n_err++; $display("FAIL first_nclk row%0d: got %0d want %0d", row, cap_n_pix, COLS); end
      for (int c = 0; c < COLS; c++) begin
        n_cmp++; if (cap_addr[c] != row * COLS + c) begin n_err++;
          $display("FAIL first_addr row%0d col%0d: got %0d want %0d", row, c, cap_addr[c], row * COLS + c); end
        n_cmp++; if (cap_pix[c] !== exp_pix(row * COLS + c, 1'b0, 1)) begin n_err++;
          $display("FAIL first_pix row%0d col%0d: got %b want %b", row, c, cap_pix[c], exp_pix(row * COLS + c, 1'b0, 1)); end
      end
      n_cmp++; if (cap_rowsel !== RW'(row)) begin n_err++; $display("FAIL first_rowsel: got %0d want %0d", cap_rowsel, row); end
      n_cmp++; if (cap_blank_low != (row == 0 ? 0 : UNIT)) begin n_err++;
        $display("FAIL first_window row%0d: got %0d want %0d", row, cap_blank_low, (row == 0 ? 0 : UNIT)); end
      n_cmp++; if (cap_done != 0) begin n_err++; $display("FAIL first_done row%0d: got %0d want 0", row, cap_done); end
    end
  endtask

  // i_mode goes to BCM here, but the thermometer frame must complete unchanged.
  task automatic test_thermo_mode_hold();
    mode = 1'b1;
    for (int sub = 2; sub <= 3; sub++) begin
      for (int row = 0; row < ROWS; row++) begin
        capture_row();
        n_cmp++; if (cap_timeout !== 1'b0) begin n_err++; $display("FAIL thermo_timeout sub%0d: got latch none want latch", sub); end
        for (int c = 0; c < COLS; c++) begin
          n_cmp++; if (cap_pix[c] !== exp_pix(row * COLS + c, 1'b0, sub)) begin n_err++;
            $display("FAIL thermo_pix sub%0d row%0d col%0d: got %b want %b", sub, row, c, cap_pix[c], exp_pix(row * COLS + c, 1'b0, sub)); end
        end
        n_cmp++; if (cap_pix[0][3] !== (sub < 3)) begin n_err++;
          $display("FAIL thermo_g1 sub%0d: got %b want %b", sub, cap_pix[0][3], (sub < 3)); end
        n_cmp++; if (cap_blank_low != UNIT) begin n_err++; $display("FAIL thermo_window: got %0d want %0d", cap_blank_low, UNIT); end
        n_cmp++; if (cap_done != ((sub == 3 && row == 1) ? 1 : 0)) begin n_err++;
          $display("FAIL thermo_done sub%0d row%0d: got %0d want %0d", sub, row, cap_done, ((sub == 3 && row == 1) ? 1 : 0)); end
      end
    end
  endtask

  task automatic test_bcm();
    for (int pl = 0; pl < DEPTH; pl++) begin
      for (int row = 0; row < ROWS; row++) begin
        capture_row();
        n_cmp++; if (cap_timeout !== 1'b0) begin n_err++; $display("FAIL bcm_timeout plane%0d: got latch none want latch", pl); end
        for (int c = 0; c < COLS; c++) begin
          n_cmp++; if (cap_pix[c] !== exp_pix(row * COLS + c, 1'b1, pl)) begin n_err++;
            $display("FAIL bcm_pix plane%0d row%0d col%0d: got %b want %b", pl, row, c, cap_pix[c], exp_pix(row * COLS + c, 1'b1, pl)); end
        end
        n_cmp++; if (cap_pix[0][4] !== (pl == 1)) begin n_err++;
          $display("FAIL bcm_r0 plane%0d: got %b want %b", pl, cap_pix[0][4], (pl == 1)); end
        n_cmp++; if (cap_blank_low != ((pl == 1 && row == 1) ? 2 * UNIT : UNIT)) begin n_err++;
          $display("FAIL bcm_window plane%0d row%0d: got %0d want %0d", pl, row, cap_blank_low, ((pl == 1 && row == 1) ? 2 * UNIT : UNIT)); end
        n_cmp++; if (cap_done != ((pl == 1 && row == 1) ? 1 : 0)) begin n_err++;
          $display("FAIL bcm_done plane%0d row%0d: got %0d want %0d", pl, row, cap_done, ((pl == 1 && row == 1) ? 1 : 0)); end
        n_cmp++; if (cap_rowsel !== RW'(row)) begin n_err++; $display("FAIL bcm_rowsel: got %0d want %0d", cap_rowsel, row); end
      end
    end
  endtask

  // Half brightness: plane-1 window (16) lit 8, plane-0 window (8) lit 4.
  task automatic test_brightness();
    bright = 8'd127;
    capture_row();
    n_cmp++; if (cap_blank_low != 8) begin n_err++; $display("FAIL bright_plane1: got %0d want 8", cap_blank_low); end
    capture_row();
    n_cmp++; if (cap_blank_low != 4) begin n_err++; $display("FAIL bright_plane0: got %0d want 4", cap_blank_low); end
    bright = 8'd255;
  endtask

  task automatic test_reset_mid_shift();
    bit hit;
    hit = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      if (rd_en && rd_addr == AW'(2)) hit = 1;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL midreset_reach: got col2 none want col2"); end
    mode = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rd_en, dclk, latch, done} !== 4'b0) begin n_err++;
      $display("FAIL midreset_strobes: got %b want 0000", {rd_en, dclk, latch, done}); end
    n_cmp++; if (blank !== 1'b1) begin n_err++; $display("FAIL midreset_blank: got %b want 1", blank); end
    n_cmp++; if ({r, g, b} !== 6'b0) begin n_err++; $display("FAIL midreset_rgb: got %b want 0", {r, g, b}); end
    n_cmp++; if (rd_addr !== '0) begin n_err++; $display("FAIL midreset_addr: got %0d want 0", rd_addr); end
    rst = 1'b0;
    capture_row();
    n_cmp++; if (cap_addr[0] != 0) begin n_err++; $display("FAIL restart_addr: got %0d want 0", cap_addr[0]); end
    for (int c = 0; c < COLS; c++) begin
      n_cmp++; if (cap_pix[c] !== exp_pix(c, 1'b0, 1)) begin n_err++;
        $display("FAIL restart_pix col%0d: got %b want %b", c, cap_pix[c], exp_pix(c, 1'b0, 1)); end
    end
  endtask

  task automatic test_ram_lat3();
    int clk_cyc[0:7];
    int addr_seen[0:7];
    logic [5:0] pix[0:7];
    logic [5:0] prev;
    int n_clk, n_rd, viol;
    n_clk = 0; n_rd = 0; viol = 0; prev = '0;
    rst_b = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rd_en_b) begin
        if (n_rd < 8) addr_seen[n_rd] = int'(rd_addr_b);
        n_rd++;
      end
      if (dclk_b) begin
        if ({r_b, g_b, b_b} !== prev) viol++;
        if (n_clk < 8) begin clk_cyc[n_clk] = cyc; pix[n_clk] = {r_b, g_b, b_b}; end
        n_clk++;
      end
      prev = {r_b, g_b, b_b};
    end
    n_cmp++; if (n_clk < COLS) begin n_err++; $display("FAIL lat3_nclk: got %0d want >= %0d", n_clk, COLS); end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL lat3_change_on_clk: got %0d want 0", viol); end
    for (int c = 0; c < COLS && c < n_clk; c++) begin
      n_cmp++; if (clk_cyc[c] != 4 + 5 * c) begin n_err++;
        $display("FAIL lat3_period col%0d: got cycle %0d want %0d", c, clk_cyc[c], 4 + 5 * c); end
      n_cmp++; if (addr_seen[c] != c) begin n_err++;
        $display("FAIL lat3_addr col%0d: got %0d want %0d", c, addr_seen[c], c); end
      n_cmp++; if (pix[c] !== exp_pix(c, 1'b0, 1)) begin n_err++;
        $display("FAIL lat3_pix col%0d: got %b want %b", c, pix[c], exp_pix(c, 1'b0, 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_first_rows();
    test_thermo_mode_hold();
    test_bcm();
    test_brightness();
    test_reset_mid_shift();
    test_ram_lat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
